// File: rtl/c3lib_ckdiv_mon_ctn_if.sv
// Bundle between the divided-clock monitor and whatever drives/observes it.
// master drives the monitored clock and configuration; slave is the monitor.
interface c3lib_ckdiv_mon_ctn_if #(
    parameter int DIV_W = 4
) ();
    logic             clk_div_in;
    logic             cfg_en;
    logic [DIV_W-1:0] cfg_half_period;
    logic             err_clr;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [DIV_W:0]   phase;
    logic             locked;
    logic             err_sticky;

    modport master (
        output clk_div_in, cfg_en, cfg_half_period, err_clr,
        input  rise_pulse, fall_pulse, phase, locked, err_sticky
    );

    modport slave (
        input  clk_div_in, cfg_en, cfg_half_period, err_clr,
        output rise_pulse, fall_pulse, phase, locked, err_sticky
    );
endinterface

// File: rtl/c3lib_ckdiv_mon_ctn.sv
// Divided-clock monitor: samples clk_div_in on clk_in, checks each half-period
// against cfg_half_period, declares lock and flags errors once locked.
module c3lib_ckdiv_mon_ctn #(
    parameter int DIV_W    = 4,
    parameter int LOCK_CNT = 4
) (
    input logic                   clk_in,
    input logic                   rst,
    c3lib_ckdiv_mon_ctn_if.slave  mon
);
    typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCK} state_t;

    localparam logic [DIV_W-1:0] HP_MAX    = '1;
    localparam logic [DIV_W-1:0] HP_ONE    = DIV_W'(1);
    localparam logic [DIV_W:0]   PH_MAX    = '1;
    localparam logic [DIV_W:0]   PH_ONE    = (DIV_W+1)'(1);
    localparam logic [3:0]       GOOD_LOCK = 4'(LOCK_CNT);

    state_t           state, state_nxt;
    logic             prev_q;
    logic [DIV_W-1:0] hp_cnt;
    logic [3:0]       good_cnt, good_nxt;
    logic             stall_seen;
    logic             rise_q, fall_q, locked_q, err_q;
    logic [DIV_W:0]   phase_q;

    logic run, edge_s, rise_s, match, stall, bad, err_set;

    assign run    = mon.cfg_en && (mon.cfg_half_period != '0);
    assign edge_s = mon.clk_div_in != prev_q;
    assign rise_s = mon.clk_div_in & ~prev_q;
    assign match  = hp_cnt == mon.cfg_half_period;
    // A stall is reported once, then suppressed until the next sampled edge.
    assign stall  = !edge_s && (hp_cnt > mon.cfg_half_period) && !stall_seen;
    assign bad    = (edge_s && !match) || stall;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_set   = 1'b0;
        case (state)
            IDLE:  state_nxt = ACQ;
            ACQ: begin
                // first rising edge only aligns us; it is not judged
                if (rise_s) begin
                    state_nxt = TRACK;
                    good_nxt  = 4'd0;
                end
            end
            TRACK: begin
                if (edge_s && match) begin
                    good_nxt = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == GOOD_LOCK) state_nxt = LOCK;
                end else if (bad) begin
                    good_nxt = 4'd0;
                end
            end
            LOCK: begin
                if (bad) begin
                    err_set   = 1'b1;
                    good_nxt  = 4'd0;
                    state_nxt = TRACK;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!run) begin
            state_nxt = IDLE;
            good_nxt  = 4'd0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            prev_q     <= 1'b0;
            hp_cnt     <= '0;
            good_cnt   <= 4'd0;
            stall_seen <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            phase_q    <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_nxt;
            prev_q     <= mon.clk_div_in;
            hp_cnt     <= edge_s ? HP_ONE : ((hp_cnt == HP_MAX) ? hp_cnt : hp_cnt + HP_ONE);
            stall_seen <= !edge_s && (stall_seen || (hp_cnt > mon.cfg_half_period));
            rise_q     <= run && rise_s;
            fall_q     <= run && edge_s && !rise_s;
            locked_q   <= state_nxt == LOCK;
            phase_q    <= ((state_nxt != LOCK) || rise_s) ? '0
                        : ((phase_q == PH_MAX) ? phase_q : phase_q + PH_ONE);
            // set beats clear when both land in the same cycle
            err_q      <= err_set | (err_q & ~mon.err_clr);
        end
    end

    assign mon.rise_pulse = rise_q;
    assign mon.fall_pulse = fall_q;
    assign mon.phase      = phase_q;
    assign mon.locked     = locked_q;
    assign mon.err_sticky = err_q;
endmodule

// File: tb/tb_c3lib_ckdiv_mon_ctn.sv
// Bench for c3lib_ckdiv_mon_ctn: vector table, directed corner sequences and
// randomized clocks checked against a timestamp-based reference model.
module tb_c3lib_ckdiv_mon_ctn;
    localparam int DIV_W    = 4;
    localparam int LOCK_CNT = 4;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_in = ~clk_in;

    c3lib_ckdiv_mon_ctn_if #(.DIV_W(DIV_W)) mif ();

    c3lib_ckdiv_mon_ctn #(.DIV_W(DIV_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .mon    (mif)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // outputs packed as {rise, fall, phase[4:0], locked, err}
    function automatic int outs();
        return int'({mif.rise_pulse, mif.fall_pulse, mif.phase, mif.locked, mif.err_sticky});
    endfunction

    task automatic step(input logic r, input logic d, input logic e, input logic c,
                        input logic [3:0] hp);
        rst                 = r;
        mif.clk_div_in      = d;
        mif.cfg_en          = e;
        mif.err_clr         = c;
        mif.cfg_half_period = hp;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    typedef struct {
        logic       rst;
        logic       din;
        logic       clr;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t vec(input logic r, input logic d, input logic c,
                                 input logic ri, input logic fa, input logic [4:0] ph,
                                 input logic lk, input logic er);
        vec_t v;
        v.rst = r; v.din = d; v.clr = c;
        v.exp = {ri, fa, ph, lk, er};
        return v;
    endfunction

    // Reference model: judges half-periods by cycle timestamps between edges.
    localparam int M_OFF = 0, M_WAIT = 1, M_CNT = 2, M_LOCK = 3;
    int   m_t = 0, m_last = 0, m_mode = M_OFF, m_good = 0, m_ph = 0;
    logic m_prev = 1'b0, m_stall = 1'b0, m_err = 1'b0;
    logic m_rise = 1'b0, m_fall = 1'b0, m_lk = 1'b0;

    always @(posedge clk_in) begin : model
        int  meas, hpv;
        bit  run, edg, ris, bad, good_edge;
        m_t++;
        if (rst) begin
            m_mode = M_OFF; m_prev = 1'b0; m_last = m_t + 1; m_good = 0;
            m_stall = 1'b0; m_err = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            m_lk = 1'b0; m_ph = 0;
        end else begin
            hpv       = int'(mif.cfg_half_period);
            run       = mif.cfg_en && hpv != 0;
            edg       = mif.clk_div_in != m_prev;
            ris       = mif.clk_div_in && !m_prev;
            meas      = m_t - m_last;
            if (meas > 15) meas = 15;
            good_edge = edg && meas == hpv;
            bad       = (edg && meas != hpv) || (!edg && meas > hpv && !m_stall);
            if (edg) begin
                m_last  = m_t;
                m_stall = 1'b0;
            end else if (meas > hpv) begin
                m_stall = 1'b1;
            end
            if (m_mode == M_LOCK && bad) m_err = 1'b1;
            else if (mif.err_clr)        m_err = 1'b0;
            if (!run) begin
                m_mode = M_OFF;
                m_good = 0;
            end else begin
                case (m_mode)
                    M_OFF:  m_mode = M_WAIT;
                    M_WAIT: if (ris) begin m_mode = M_CNT; m_good = 0; end
                    M_CNT: begin
                        if (good_edge) begin
                            m_good++;
                            if (m_good == LOCK_CNT) m_mode = M_LOCK;
                        end else if (bad) m_good = 0;
                    end
                    default: if (bad) begin m_mode = M_CNT; m_good = 0; end
                endcase
            end
            m_rise = run && ris;
            m_fall = run && edg && !ris;
            m_lk   = m_mode == M_LOCK;
            m_ph   = (m_mode != M_LOCK || ris) ? 0 : ((m_ph < 31) ? m_ph + 1 : 31);
            m_prev = mif.clk_div_in;
        end
    end

    vec_t tbl[36];

    initial begin
        logic d;
        logic [3:0] rhp;
        logic ren, rlvl;
        int   rem, nlock, nrise, seen;

        mif.clk_div_in = 1'b0; mif.cfg_en = 1'b1; mif.err_clr = 1'b0;
        mif.cfg_half_period = 4'd2;

        // div-4 lock, stretched-high error + relock, err_clr vs set collision
        tbl[0]  = vec(1,0,0, 0,0,0,0,0);  tbl[1]  = vec(0,0,0, 0,0,0,0,0);
        tbl[2]  = vec(0,1,0, 1,0,0,0,0);  tbl[3]  = vec(0,1,0, 0,0,0,0,0);
        tbl[4]  = vec(0,0,0, 0,1,0,0,0);  tbl[5]  = vec(0,0,0, 0,0,0,0,0);
        tbl[6]  = vec(0,1,0, 1,0,0,0,0);  tbl[7]  = vec(0,1,0, 0,0,0,0,0);
        tbl[8]  = vec(0,0,0, 0,1,0,0,0);  tbl[9]  = vec(0,0,0, 0,0,0,0,0);
        tbl[10] = vec(0,1,0, 1,0,0,1,0);  tbl[11] = vec(0,1,0, 0,0,1,1,0);
        tbl[12] = vec(0,0,0, 0,1,2,1,0);  tbl[13] = vec(0,0,0, 0,0,3,1,0);
        tbl[14] = vec(0,1,0, 1,0,0,1,0);  tbl[15] = vec(0,1,0, 0,0,1,1,0);
        tbl[16] = vec(0,0,0, 0,1,2,1,0);  tbl[17] = vec(0,0,0, 0,0,3,1,0);
        tbl[18] = vec(0,1,0, 1,0,0,1,0);  tbl[19] = vec(0,1,0, 0,0,1,1,0);
        tbl[20] = vec(0,1,0, 0,0,2,1,0);  tbl[21] = vec(0,0,0, 0,1,0,0,1);
        tbl[22] = vec(0,0,0, 0,0,0,0,1);  tbl[23] = vec(0,1,0, 1,0,0,0,1);
        tbl[24] = vec(0,1,0, 0,0,0,0,1);  tbl[25] = vec(0,0,0, 0,1,0,0,1);
        tbl[26] = vec(0,0,0, 0,0,0,0,1);  tbl[27] = vec(0,1,0, 1,0,0,0,1);
        tbl[28] = vec(0,1,0, 0,0,0,0,1);  tbl[29] = vec(0,0,0, 0,1,1,1,1);
        tbl[30] = vec(0,0,0, 0,0,2,1,1);  tbl[31] = vec(0,1,0, 1,0,0,1,1);
        tbl[32] = vec(0,1,0, 0,0,1,1,1);  tbl[33] = vec(0,1,0, 0,0,2,1,1);
        tbl[34] = vec(0,0,1, 0,1,0,0,1);  tbl[35] = vec(0,0,1, 0,0,0,0,0);

        @(negedge clk_in);
        for (int i = 0; i < 36; i++) begin
            step(tbl[i].rst, tbl[i].din, 1'b1, tbl[i].clr, 4'd2);
            chk($sformatf("vec%0d", i), outs(), int'(tbl[i].exp));
        end

        // div-2 with half-period 1, then disable
        step(1, 0, 1, 0, 4'd1);
        for (int k = 1; k <= 6; k++) begin
            step(0, logic'((k % 2) == 0), 1, 0, 4'd1);
            if (k == 5) chk("div2_prelock", int'(mif.locked), 0);
        end
        chk("div2_lock", outs(), int'(9'b1_0_00000_1_0));
        step(0, 0, 1, 0, 4'd1);
        chk("div2_ph1", outs(), int'(9'b0_1_00001_1_0));
        step(0, 1, 1, 0, 4'd1);
        chk("div2_ph0", outs(), int'(9'b1_0_00000_1_0));
        step(0, 0, 0, 0, 4'd1);
        chk("div2_disable", outs(), 0);

        // relock, then a one-cycle reset while locked
        d = 1'b0; seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            d = ~d;
            step(0, d, 1, 0, 4'd1);
            if (mif.locked) seen = 1;
        end
        chk("div2_relock", seen, 1);
        d = ~d;
        step(1, d, 1, 0, 4'd1);
        chk("rst_in_lock", outs(), 0);
        for (int k = 1; k <= 5; k++) begin
            d = ~d;
            step(0, d, 1, 0, 4'd1);
            chk($sformatf("rst_nolock%0d", k), int'(mif.locked), 0);
        end
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            d = ~d;
            step(0, d, 1, 0, 4'd1);
            if (mif.locked) seen = 1;
        end
        chk("rst_relock", seen, 1);

        // clk_div_in stuck high
        step(1, 0, 1, 0, 4'd2);
        nlock = 0; nrise = 0;
        for (int k = 0; k < 40; k++) begin
            step(0, 1, 1, 0, 4'd2);
            nlock += int'(mif.locked);
            nrise += int'(mif.rise_pulse);
        end
        chk("hold_nolock", nlock, 0);
        chk("hold_one_rise", nrise, 1);
        chk("hold_hp_sat", int'(dut.hp_cnt), 15);
        chk("hold_phase", int'(mif.phase), 0);

        // randomized clocks against the model
        rhp = 4'd2; ren = 1'b1; rlvl = 1'b0; rem = 0;
        step(1, 0, 1, 0, rhp);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) rhp = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 199) == 0) ren = ~ren;
            if (rem == 0) begin
                rlvl = ~rlvl;
                rem  = ($urandom_range(0, 19) < 17) ? int'(rhp) : int'($urandom_range(1, 7));
                if (rem == 0) rem = 1;
            end
            rem--;
            step(logic'($urandom_range(0, 499) == 0), rlvl, ren,
                 logic'($urandom_range(0, 9) == 0), rhp);
            chk("rand", outs(), int'({m_rise, m_fall, 5'(m_ph), m_lk, m_err}));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
